// File: rtl/qam4_frame_scheduler.sv
// QAM4 frame scheduler: gathers 16 dibits per frame into ping-pong banks, Gray-maps them
// onto the constellation ROM points and streams the symbols out over valid/ready.
module qam4_frame_scheduler #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned FRAME_LEN = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [WORD_SIZE-1:0] i_point1_re,
   input  logic [WORD_SIZE-1:0] i_point1_im,
   input  logic [WORD_SIZE-1:0] i_point2_re,
   input  logic [WORD_SIZE-1:0] i_point2_im,
   input  logic [WORD_SIZE-1:0] i_point3_re,
   input  logic [WORD_SIZE-1:0] i_point3_im,
   input  logic [WORD_SIZE-1:0] i_point4_re,
   input  logic [WORD_SIZE-1:0] i_point4_im,
   input  logic                 i_bits_valid,
   input  logic [1:0]           i_bits,
   output logic                 o_bits_ready,
   output logic                 o_sym_valid,
   output logic [WORD_SIZE-1:0] o_sym_re,
   output logic [WORD_SIZE-1:0] o_sym_im,
   output logic [3:0]           o_sym_idx,
   output logic                 o_sym_last,
   input  logic                 i_sym_ready,
   output logic [7:0]           o_frame_cnt,
   output logic                 o_busy
);

   localparam int unsigned IDX_W    = 4;
   localparam int unsigned CNT_W    = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [1:0] WARM_DONE = 2'd2;

   typedef enum logic [1:0] {WARM, IDLE, SEND} state_t;

   state_t                           state_q, state_d;
   logic [1:0]                       warm_cnt_q, warm_cnt_d;
   logic [1:0][FRAME_LEN-1:0][1:0]   bank_q, bank_d;
   logic [1:0]                       full_q, full_d;
   logic                             wr_bank_q, wr_bank_d;
   logic [IDX_W-1:0]                 wr_idx_q, wr_idx_d;
   logic                             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]                 rd_idx_q, rd_idx_d;
   logic                             sym_valid_q, sym_valid_d;
   logic [WORD_SIZE-1:0]             sym_re_q, sym_re_d;
   logic [WORD_SIZE-1:0]             sym_im_q, sym_im_d;
   logic [IDX_W-1:0]                 sym_idx_q, sym_idx_d;
   logic                             sym_last_q, sym_last_d;
   logic [CNT_W-1:0]                 frame_cnt_q, frame_cnt_d;
   logic                             busy_q, busy_d;

   logic                             bits_ready_c;
   logic                             accept_c;
   logic                             load_c;
   logic [1:0]                       rd_dibit_c;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= WARM;
         warm_cnt_q  <= '0;
         bank_q      <= '0;
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         sym_valid_q <= 1'b0;
         sym_re_q    <= '0;
         sym_im_q    <= '0;
         sym_idx_q   <= '0;
         sym_last_q  <= 1'b0;
         frame_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         warm_cnt_q  <= warm_cnt_d;
         bank_q      <= bank_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         wr_idx_q    <= wr_idx_d;
         rd_bank_q   <= rd_bank_d;
         rd_idx_q    <= rd_idx_d;
         sym_valid_q <= sym_valid_d;
         sym_re_q    <= sym_re_d;
         sym_im_q    <= sym_im_d;
         sym_idx_q   <= sym_idx_d;
         sym_last_q  <= sym_last_d;
         frame_cnt_q <= frame_cnt_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      warm_cnt_d  = warm_cnt_q;
      bank_d      = bank_q;
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      wr_idx_d    = wr_idx_q;
      rd_bank_d   = rd_bank_q;
      rd_idx_d    = rd_idx_q;
      sym_re_d    = sym_re_q;
      sym_im_d    = sym_im_q;
      sym_idx_d   = sym_idx_q;
      sym_last_d  = sym_last_q;
      frame_cnt_d = frame_cnt_q;
      rd_dibit_c  = bank_q[rd_bank_q][rd_idx_q];

      bits_ready_c = (state_q != WARM) && !full_q[wr_bank_q];
      accept_c     = i_bits_valid && bits_ready_c;
      load_c       = full_q[rd_bank_q] && (!sym_valid_q || i_sym_ready);

      // Warm-up hides the ROM's zero output right after reset
      case (state_q)
         WARM: begin
            if (warm_cnt_q == WARM_DONE) state_d = IDLE;
            else                         warm_cnt_d = warm_cnt_q + 2'd1;
         end
         default: state_d = load_c ? SEND : IDLE;
      endcase

      if (accept_c) begin
         bank_d[wr_bank_q][wr_idx_q] = i_bits;
         if (wr_idx_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end

      if (load_c) begin
         case (rd_dibit_c)
            2'b00:   begin sym_re_d = i_point1_re; sym_im_d = i_point1_im; end
            2'b01:   begin sym_re_d = i_point2_re; sym_im_d = i_point2_im; end
            2'b11:   begin sym_re_d = i_point3_re; sym_im_d = i_point3_im; end
            default: begin sym_re_d = i_point4_re; sym_im_d = i_point4_im; end
         endcase
         sym_idx_d  = rd_idx_q;
         sym_last_d = (rd_idx_q == LAST_IDX);
         if (rd_idx_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_idx_d          = '0;
         end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
         end
      end

      sym_valid_d = load_c || (sym_valid_q && !i_sym_ready);

      if (sym_valid_q && i_sym_ready && sym_last_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);

      busy_d = (|full_d) || sym_valid_d;
   end

   assign o_bits_ready = bits_ready_c;
   assign o_sym_valid  = sym_valid_q;
   assign o_sym_re     = sym_re_q;
   assign o_sym_im     = sym_im_q;
   assign o_sym_idx    = sym_idx_q;
   assign o_sym_last   = sym_last_q;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_qam4_frame_scheduler.sv
// Bench for qam4_frame_scheduler: frame-level queue model compared every cycle, plus directed pins.
module tb_qam4_frame_scheduler;

   localparam logic [15:0] POS_RE = 16'h016A;
   localparam logic [15:0] NEG_RE = 16'hFE96;
   localparam logic [15:0] POS_IM = 16'h00C9;
   localparam logic [15:0] NEG_IM = 16'hFF37;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bits_valid = 1'b0;
   logic [1:0]  bits = 2'b00;
   logic        sym_ready = 1'b0;
   logic        bits_ready;
   logic        sym_valid;
   logic [15:0] sym_re, sym_im;
   logic [3:0]  sym_idx;
   logic        sym_last;
   logic [7:0]  frame_cnt;
   logic        busy;

   qam4_frame_scheduler #(.WORD_SIZE(16), .FRAME_LEN(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_point1_re(POS_RE), .i_point1_im(POS_IM),
      .i_point2_re(POS_RE), .i_point2_im(NEG_IM),
      .i_point3_re(NEG_RE), .i_point3_im(NEG_IM),
      .i_point4_re(NEG_RE), .i_point4_im(POS_IM),
      .i_bits_valid(bits_valid), .i_bits(bits), .o_bits_ready(bits_ready),
      .o_sym_valid(sym_valid), .o_sym_re(sym_re), .o_sym_im(sym_im),
      .o_sym_idx(sym_idx), .o_sym_last(sym_last), .i_sym_ready(sym_ready),
      .o_frame_cnt(frame_cnt), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Model: dibits of the frame being filled, dibits of completed frames awaiting output
   logic [1:0]  fillq[$];
   logic [1:0]  storeq[$];
   int          nfull = 0, rd_pos = 0, m_warm = 0;
   logic        m_valid = 0, m_last = 0;
   logic [15:0] m_re = 0, m_im = 0;
   logic [3:0]  m_idx = 0;
   logic [7:0]  m_cnt = 0;

   function automatic logic m_ready();
      return (m_warm >= 3) && (nfull < 2);
   endfunction

   task automatic model_step();
      logic acc, load;
      logic [1:0] d;
      if (!rst_n) begin
         fillq.delete(); storeq.delete();
         nfull = 0; rd_pos = 0; m_warm = 0;
         m_valid = 0; m_last = 0; m_re = 0; m_im = 0; m_idx = 0; m_cnt = 0;
         return;
      end
      acc  = bits_valid && m_ready();
      load = (nfull > 0) && (!m_valid || sym_ready);
      if (m_valid && sym_ready && m_last) m_cnt = m_cnt + 8'd1;
      if (load) begin
         d     = storeq.pop_front();
         m_re  = d[1] ? NEG_RE : POS_RE;
         m_im  = d[0] ? NEG_IM : POS_IM;
         m_idx = 4'(rd_pos);
         m_last = (rd_pos == 15);
         rd_pos = (rd_pos + 1) % 16;
         if (rd_pos == 0) nfull--;
      end
      m_valid = load || (m_valid && !sym_ready);
      if (acc) begin
         fillq.push_back(bits);
         if (fillq.size() == 16) begin
            foreach (fillq[i]) storeq.push_back(fillq[i]);
            fillq.delete();
            nfull++;
         end
      end
      if (m_warm < 3) m_warm++;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("bits_ready", 32'(bits_ready), 32'(m_ready()));
      check("sym_valid", 32'(sym_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'((nfull > 0) || m_valid));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      if (m_valid) begin
         check("sym_re", 32'(sym_re), 32'(m_re));
         check("sym_im", 32'(sym_im), 32'(m_im));
         check("sym_idx", 32'(sym_idx), 32'(m_idx));
         check("sym_last", 32'(sym_last), 32'(m_last));
      end
   end

   // Offer one dibit until accepted; entered and left at a falling edge
   task automatic push(input logic [1:0] b);
      int guard = 0;
      bits_valid = 1'b1;
      bits = b;
      while (!bits_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("push_timeout", 32'(guard), 32'(0));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bits_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int acc;
      int guard;
      logic [1:0] pat [4];
      pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;

      // Reset / warm-up with valid held high
      repeat (3) @(negedge clk);
      sym_ready = 1'b1;
      bits_valid = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #2 check("warm_e1_ready", 32'(bits_ready), 32'(0));
      check("warm_e1_valid", 32'(sym_valid), 32'(0));
      @(posedge clk); #2 check("warm_e2_ready", 32'(bits_ready), 32'(0));
      @(posedge clk); #2 check("warm_e3_ready", 32'(bits_ready), 32'(1));
      @(negedge clk);
      bits_valid = 1'b0;
      do_reset();

      // Single frame of 00
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) push(2'b00);
      bits_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("single_cnt", 32'(frame_cnt), 32'(1));
      check("single_busy", 32'(busy), 32'(0));

      // Gray map pattern
      for (int i = 0; i < 16; i++) push(pat[i % 4]);
      bits_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("gray_cnt", 32'(frame_cnt), 32'(2));

      // Backpressure and ping-pong
      sym_ready = 1'b0;
      bits_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 48; i++) begin
         bits = 2'($urandom);
         if (bits_ready) acc++;
         @(negedge clk);
      end
      bits_valid = 1'b0;
      check("bp_accepted", 32'(acc), 32'(32));
      check("bp_ready_low", 32'(bits_ready), 32'(0));
      check("bp_valid", 32'(sym_valid), 32'(1));
      check("bp_idx_held", 32'(sym_idx), 32'(0));
      sym_ready = 1'b1;
      repeat (40) @(negedge clk);
      check("bp_cnt", 32'(frame_cnt), 32'(4));

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         bits_valid = ($urandom % 4) != 0;
         bits       = 2'($urandom);
         sym_ready  = ($urandom % 3) != 0;
         @(negedge clk);
      end
      bits_valid = 1'b0;
      sym_ready = 1'b1;
      repeat (40) @(negedge clk);

      // Reset during symbol idx 7
      for (int i = 0; i < 16; i++) push(2'($urandom));
      bits_valid = 1'b0;
      guard = 0;
      while (!(sym_valid && sym_idx == 4'd7) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("idx7_reached", 32'(guard < 100), 32'(1));
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(sym_valid), 32'(0));
      check("rst_re", 32'(sym_re), 32'(0));
      check("rst_idx", 32'(sym_idx), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'(0));
      for (int i = 0; i < 16; i++) push(2'($urandom));
      bits_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("post_rst_cnt", 32'(frame_cnt), 32'(1));

      // Counter wrap: 256 frames of 11
      do_reset();
      repeat (4) @(negedge clk);
      for (int i = 0; i < 256 * 16; i++) push(2'b11);
      bits_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("wrap_cnt", 32'(frame_cnt), 32'(0));
      check("wrap_busy", 32'(busy), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
